// File: rtl/hamming_enc_sched.sv
// Two-source round-robin scheduler for one shared Hamming(21,16) encoder with a 2-entry tagged output queue.
// Optional even overall parity on out_code[21] when HAMMING_SECDED_PARITY_EN is defined.
module hamming_precompute (
  input  logic [15:0] m,
  output logic [20:0] y
);
  logic [20:0] d;
  // Data bits occupy the non-power-of-two positions (1-based); parity slots left 0 here
  assign d = {m[15:11], 1'b0, m[10:4], 1'b0, m[3:1], 1'b0, m[0], 2'b00};
  always_comb begin
    y     = d;
    y[0]  = ^(d & 21'h155555);
    y[1]  = ^(d & 21'h066666);
    y[3]  = ^(d & 21'h187878);
    y[7]  = ^(d & 21'h007F80);
    y[15] = ^(d & 21'h1F8000);
  end
endmodule

module hamming_enc_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in0_valid,
  input  logic [15:0]      in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [15:0]      in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [21:0]      out_code,
  output logic             out_src,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;
  typedef struct packed {
    logic        src;
    logic [21:0] code;
  } q_ent_t;

  occ_t        occ;
  logic        rr_ptr;
  q_ent_t      head, tail, new_ent;
  logic        sel, full, push, pop;
  logic [15:0] enc_m;
  logic [20:0] enc_y;

  // sel is the source that would win this cycle; idle cycles point at rr_ptr
  always_comb begin
    if (in0_valid && in1_valid) sel = rr_ptr;
    else if (in1_valid)         sel = 1'b1;
    else if (in0_valid)         sel = 1'b0;
    else                        sel = rr_ptr;
  end

  assign full      = (occ == FULL);
  assign in0_ready = !full && !sel;
  assign in1_ready = !full &&  sel;
  assign push      = (in0_ready && in0_valid) || (in1_ready && in1_valid);
  assign out_valid = (occ != EMPTY);
  assign pop       = out_valid && out_ready;
  assign enc_m     = sel ? in1_data : in0_data;

  hamming_precompute u_enc (.m(enc_m), .y(enc_y));

  always_comb begin
    new_ent.src  = sel;
`ifdef HAMMING_SECDED_PARITY_EN
    new_ent.code = {^enc_y, enc_y};
`else
    new_ent.code = {1'b0, enc_y};
`endif
  end

  assign out_code = head.code;
  assign out_src  = head.src;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= EMPTY;
      rr_ptr <= 1'b0;
      cnt0   <= '0;
      cnt1   <= '0;
      head   <= '0;
      tail   <= '0;
    end else begin
      if (push) begin
        rr_ptr <= ~sel;
        if (sel) cnt1 <= cnt1 + 1'b1;
        else     cnt0 <= cnt0 + 1'b1;
      end
      case (occ)
        EMPTY: if (push) begin
          head <= new_ent;
          occ  <= ONE;
        end
        ONE: begin
          if (push && pop) head <= new_ent;
          else if (push) begin
            tail <= new_ent;
            occ  <= FULL;
          end else if (pop) occ <= EMPTY;
        end
        FULL: if (pop) begin
          head <= tail;
          occ  <= ONE;
        end
        default: occ <= EMPTY;
      endcase
    end
  end
endmodule

// File: tb/tb_hamming_enc_sched.sv
// Randomized and directed bench for hamming_enc_sched against a queue-based behavioural model.
module tb_hamming_enc_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic        in0_valid, in1_valid, out_ready;
  logic [15:0] in0_data, in1_data;
  logic        in0_ready, in1_ready, out_valid, out_src;
  logic [21:0] out_code;
  logic [15:0] cnt0, cnt1;
  logic        s_in0_ready, s_in1_ready, s_out_valid, s_out_src;
  logic [21:0] s_out_code;
  logic [3:0]  s_cnt0, s_cnt1;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hamming_enc_sched u_dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_code(out_code), .out_src(out_src), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  hamming_enc_sched #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(s_in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(s_in1_ready),
    .out_valid(s_out_valid), .out_code(s_out_code), .out_src(s_out_src), .out_ready(out_ready),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Textbook Hamming: 1-based positions, parity at powers of two, data fills the rest LSB first
  function automatic logic [21:0] enc(input logic [15:0] d);
    logic [21:0] y;
    int j;
    y = '0;
    j = 0;
    for (int pos = 1; pos <= 21; pos++)
      if ((pos & (pos - 1)) != 0) begin
        y[pos-1] = d[j];
        j++;
      end
    for (int k = 0; k < 5; k++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos <= 21; pos++)
        if (((pos >> k) & 1) == 1 && pos != (1 << k)) p ^= y[pos-1];
      y[(1 << k) - 1] = p;
    end
`ifdef HAMMING_SECDED_PARITY_EN
    y[21] = ^y[20:0];
`endif
    return y;
  endfunction

  typedef struct { bit src; logic [15:0] d; } ent_t;
  ent_t        q[$];
  bit          m_rr;
  int unsigned m_c0, m_c1;

  always @(negedge clk) begin
    bit win, e_r0, e_r1, acc0, acc1, e_valid;
    e_valid = (q.size() > 0);
    if (in0_valid && in1_valid) win = m_rr;
    else if (in0_valid || in1_valid) win = in1_valid;
    else win = m_rr;
    e_r0 = (q.size() < 2) && !win;
    e_r1 = (q.size() < 2) &&  win;
    if (chk_en) begin
      chk("in0_ready", in0_ready, e_r0);
      chk("in1_ready", in1_ready, e_r1);
      chk("out_valid", out_valid, e_valid);
      chk("cnt0", cnt0, m_c0 % 65536);
      chk("cnt1", cnt1, m_c1 % 65536);
      chk("cnt0_w4", s_cnt0, m_c0 % 16);
      chk("cnt1_w4", s_cnt1, m_c1 % 16);
      if (e_valid) begin
        chk("out_src", out_src, q[0].src);
        chk("out_code", out_code, enc(q[0].d));
`ifdef HAMMING_SECDED_PARITY_EN
        chk("even_weight", ^out_code, 1'b0);
`endif
      end
    end
    if (rst) begin
      q.delete();
      m_rr = 1'b0;
      m_c0 = 0;
      m_c1 = 0;
    end else begin
      acc0 = e_r0 && in0_valid;
      acc1 = e_r1 && in1_valid;
      if (e_valid && out_ready) void'(q.pop_front());
      if (acc0) begin q.push_back('{1'b0, in0_data}); m_c0++; m_rr = 1'b1; end
      if (acc1) begin q.push_back('{1'b1, in1_data}); m_c1++; m_rr = 1'b0; end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit srcs [4];
    rst = 1'b1; in0_valid = 0; in1_valid = 0; in0_data = 0; in1_data = 0; out_ready = 0;
    repeat (2) cyc();
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_code", out_code, 22'h0);
    chk("rst_cnt0", cnt0, 16'h0);
    chk("rst_cnt1", cnt1, 16'h0);
    chk("rst_in0_ready", in0_ready, 1'b1);
    chk("rst_in1_ready", in1_ready, 1'b0);

    // hand-computed codewords pin the model
    chk("pin_enc_578d", enc(16'h578D) & 22'h1FFFFF, 22'h0A786C);
    chk("pin_enc_0001", enc(16'h0001) & 22'h1FFFFF, 22'h000007);
    chk("pin_enc_8000", enc(16'h8000) & 22'h1FFFFF, 22'h108009);

    cyc();
    in0_valid = 1; in0_data = 16'h578D; out_ready = 1;
    cyc();
    in0_valid = 0;
    @(negedge clk);
    chk("single_valid", out_valid, 1'b1);
    chk("single_src", out_src, 1'b0);
    chk("single_code", out_code[20:0], 21'h0A786C);
    chk("single_cnt0", cnt0, 16'd1);

    cyc();
    in0_valid = 1; in0_data = 16'h0001; in1_valid = 1; in1_data = 16'h8000;
    cyc();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      srcs[i] = out_src;
      chk("cont_diff", ((cnt0 > cnt1) ? cnt0 - cnt1 : cnt1 - cnt0) <= 1, 1'b1);
      cyc();
    end
    for (int i = 0; i < 3; i++) chk("cont_alternate", srcs[i] ^ srcs[i+1], 1'b1);
    in0_valid = 0; in1_valid = 0;
    repeat (3) cyc();

    out_ready = 0;
    in1_valid = 1; in1_data = 16'hAAAA;
    cyc();
    in1_data = 16'h5555;
    cyc();
    in1_data = 16'h1234; in0_valid = 1;
    @(negedge clk);
    chk("bp_in0_ready", in0_ready, 1'b0);
    chk("bp_in1_ready", in1_ready, 1'b0);
    cyc();
    in0_valid = 0; in1_valid = 0; out_ready = 1;
    @(negedge clk);
    chk("bp_first", out_code, enc(16'hAAAA));
    cyc();
    @(negedge clk);
    chk("bp_second", out_code, enc(16'h5555));
    cyc();
    @(negedge clk);
    chk("bp_drained", out_valid, 1'b0);

    rst = 1; cyc(); rst = 0;
    in0_valid = 1;
    for (int i = 0; i < 17; i++) begin
      in0_data = 16'(i * 16'h1111);
      cyc();
    end
    in0_valid = 0;
    @(negedge clk);
    chk("wrap_cnt0_w4", s_cnt0, 4'd1);
    chk("wrap_cnt0", cnt0, 16'd17);

    out_ready = 0; in0_valid = 1; in0_data = 16'hBEEF;
    repeat (3) cyc();
    rst = 1;
    cyc();
    rst = 0; in0_valid = 0;
    @(negedge clk);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_cnt0", cnt0, 16'h0);
    chk("mrst_cnt1", cnt1, 16'h0);

    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst       = ($urandom_range(0, 199) == 0);
      in0_valid = $urandom_range(0, 2) != 0;
      in1_valid = $urandom_range(0, 2) != 0;
      in0_data  = 16'($urandom);
      in1_data  = 16'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
    end
    cyc();
    rst = 0;
    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
